// File: rtl/pipelined_add_sub_pkg.sv
// Shared ALU definitions: operation encodings used by the ALU decoder and the add/sub pipeline.
package pipelined_add_sub_pkg;

  localparam int unsigned ALU_OP_WIDTH = 1;

  typedef enum logic [ALU_OP_WIDTH-1:0] {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } alu_op_e;

endpackage

// File: rtl/pipelined_add_sub_if.sv
// Operand/result handshake bundle for the pipelined adder/subtractor.
interface pipelined_add_sub_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, carry_out, overflow
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, carry_out, overflow
  );

endinterface

// File: rtl/full_adder.sv
// Single-bit full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);

  assign s     = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/pipelined_add_sub_add_chunk.sv
// Combinational ripple-carry chunk built from full_adder cells; also exposes the carry into
// its top bit so the caller can derive signed overflow.
module add_chunk #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             c_msb_in
);

  logic [WIDTH:0] c;

  assign c[0] = c_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .c_in (c[i]),
      .s    (s[i]),
      .c_out(c[i+1])
    );
  end

  assign c_out    = c[WIDTH];
  assign c_msb_in = c[WIDTH-1];

endmodule

// File: rtl/pipelined_add_sub.sv
// Pipelined two's-complement add/sub: stage k resolves chunk k of the carry chain, passing the
// remaining operands, partial sum and carry forward under a single valid/ready advance.
module pipelined_add_sub
  import pipelined_add_sub_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input logic               clk,
  input logic               rst,
  pipelined_add_sub_if.slave bus
);

  localparam int unsigned CHUNK = WIDTH / STAGES;
  localparam int unsigned LAST  = STAGES - 1;

  logic                advance;
  logic [STAGES-1:0]   v_q, v_src;
  logic [STAGES-1:0]   c_q, c_src, chunk_c;
  logic                chunk_cm [STAGES];
  logic [CHUNK-1:0]    chunk_s  [STAGES];
  logic [WIDTH-1:0]    a_q      [STAGES];
  logic [WIDTH-1:0]    b_q      [STAGES];
  logic [WIDTH-1:0]    s_q      [STAGES];
  logic [WIDTH-1:0]    a_src    [STAGES];
  logic [WIDTH-1:0]    b_src    [STAGES];
  logic [WIDTH-1:0]    s_src    [STAGES];
  logic [WIDTH-1:0]    s_next   [STAGES];
  logic                ovf_q;

  assign advance = ~v_q[LAST] | bus.out_ready;

  // Stage 0 takes the raw operands; subtraction folds into ~b with a carry-in of 1.
  always_comb begin
    v_src    = '0;
    c_src    = '0;
    a_src[0] = bus.a;
    b_src[0] = (bus.sub == OP_SUB) ? ~bus.b : bus.b;
    s_src[0] = '0;
    c_src[0] = (bus.sub == OP_SUB);
    v_src[0] = bus.in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_src[k] = a_q[k-1];
      b_src[k] = b_q[k-1];
      s_src[k] = s_q[k-1];
      c_src[k] = c_q[k-1];
      v_src[k] = v_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    add_chunk #(
      .WIDTH(CHUNK)
    ) u_chunk (
      .a       (a_src[k][k*CHUNK +: CHUNK]),
      .b       (b_src[k][k*CHUNK +: CHUNK]),
      .c_in    (c_src[k]),
      .s       (chunk_s[k]),
      .c_out   (chunk_c[k]),
      .c_msb_in(chunk_cm[k])
    );
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      s_next[k]                  = s_src[k];
      s_next[k][k*CHUNK +: CHUNK] = chunk_s[k];
    end
  end

  // Only the valid bits need reset; data under an invalid stage is never exposed.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
    end else if (advance) begin
      v_q   <= v_src;
      c_q   <= chunk_c;
      ovf_q <= chunk_c[LAST] ^ chunk_cm[LAST];
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_src[k];
        b_q[k] <= b_src[k];
        s_q[k] <= s_next[k];
      end
    end
  end

  assign bus.in_ready  = advance;
  assign bus.out_valid = v_q[LAST];
  assign bus.sum       = v_q[LAST] ? s_q[LAST] : '0;
  assign bus.carry_out = v_q[LAST] & c_q[LAST];
  assign bus.overflow  = v_q[LAST] & ovf_q;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Directed and randomized checks of pipelined_add_sub against an arithmetic reference model.
module tb_pipelined_add_sub;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned STAGES = 4;

  typedef struct packed {
    logic        c;
    logic        v;
    logic [31:0] s;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipelined_add_sub_if #(.WIDTH(WIDTH)) bus ();

  pipelined_add_sub #(
    .WIDTH (WIDTH),
    .STAGES(STAGES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  res_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   n_rcv  = 0;

  function automatic res_t ref_model(logic [31:0] a, logic [31:0] b, logic sub);
    res_t r;
    if (!sub) begin
      {r.c, r.s} = {1'b0, a} + {1'b0, b};
      r.v = (a[31] == b[31]) && (r.s[31] != a[31]);
    end else begin
      r.s = a - b;
      r.c = (a >= b);
      r.v = (a[31] != b[31]) && (r.s[31] != a[31]);
    end
    return r;
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(logic v, logic [31:0] a, logic [31:0] b, logic s, logic ordy);
    bus.in_valid  = v;
    bus.a         = a;
    bus.b         = b;
    bus.sub       = s;
    bus.out_ready = ordy;
    #1;
  endtask

  function automatic res_t outs();
    return {bus.carry_out, bus.overflow, bus.sum};
  endfunction

  // Scoreboard the transfers that the coming edge will perform, then step one clock.
  task automatic cycle();
    res_t r;
    check("in_ready", 64'(bus.in_ready), 64'(!bus.out_valid || bus.out_ready));
    if (bus.out_valid && bus.out_ready) begin
      n_rcv++;
      check("out_expected", 64'(exp_q.size() > 0), 64'(1));
      if (exp_q.size() > 0) begin
        r = exp_q.pop_front();
        check("result", 64'(outs()), 64'(r));
      end
    end
    if (bus.in_valid && bus.in_ready) exp_q.push_back(ref_model(bus.a, bus.b, bus.sub));
    @(posedge clk);
    #1;
  endtask

  task automatic directed(string tag, logic [31:0] a, logic [31:0] b, logic s,
                          logic [31:0] es, logic ec, logic ev);
    int lat;
    drive(1'b1, a, b, s, 1'b1);
    cycle();
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      cycle();
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(STAGES));
    check({tag, "_sum"}, 64'(bus.sum), 64'(es));
    check({tag, "_carry"}, 64'(bus.carry_out), 64'(ec));
    check({tag, "_ovf"}, 64'(bus.overflow), 64'(ev));
    cycle();
  endtask

  logic [31:0] ra[8];
  logic [31:0] rb[8];
  logic        rs[8];

  initial begin
    int   i, c, rcv0, lat;
    logic acc;
    res_t held;

    // Reset and idle state
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_sum", 64'(bus.sum), 64'(0));
    check("rst_carry", 64'(bus.carry_out), 64'(0));
    check("rst_ovf", 64'(bus.overflow), 64'(0));
    check("rst_in_ready", 64'(bus.in_ready), 64'(1));

    // Boundary cases
    directed("add_pos_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    directed("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    directed("sub_borrow", 32'd5, 32'd7, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    directed("sub_neg_ovf", 32'h8000_0000, 32'd1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

    // Random back-to-back stream with a 3-cycle output stall
    for (int k = 0; k < 8; k++) begin
      ra[k] = $urandom;
      rb[k] = $urandom;
      rs[k] = 1'($urandom_range(0, 1));
    end
    rcv0 = n_rcv;
    i = 0;
    c = 0;
    while (i < 8 && c < 40) begin
      drive(1'b1, ra[i], rb[i], rs[i], !(c >= 5 && c <= 7));
      if (c >= 5 && c <= 7) begin
        check("stall_in_ready", 64'(bus.in_ready), 64'(0));
        check("stall_out_valid", 64'(bus.out_valid), 64'(1));
        if (c == 5) held = outs();
        else check("stall_hold", 64'(outs()), 64'(held));
      end
      acc = bus.in_ready;
      cycle();
      if (acc) i++;
      c++;
    end
    check("stream_issued", 64'(i), 64'(8));
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    while (exp_q.size() > 0 && c < 80) begin
      cycle();
      c++;
    end
    check("stream_drained", 64'(exp_q.size()), 64'(0));
    check("stream_count", 64'(n_rcv - rcv0), 64'(8));

    // Reset with 3 operations in flight; an op presented during reset must be ignored
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1);
      cycle();
    end
    rst = 1'b1;
    drive(1'b1, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      check("post_rst_valid", 64'(bus.out_valid), 64'(0));
      check("post_rst_sum", 64'(bus.sum), 64'(0));
      cycle();
    end
    directed("after_rst", 32'h0000_00FF, 32'h0000_0101, 1'b0, 32'h0000_0200, 1'b0, 1'b0);
    check("final_empty", 64'(exp_q.size()), 64'(0));

    lat = 0;
    while (lat < 6) begin
      check("idle_valid", 64'(bus.out_valid), 64'(0));
      cycle();
      lat++;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
